// File: rtl/fifo_pkg.sv
// Shared constants, FSM encoding and helpers for the FIFO read-drain block.
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W      = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A burst length of zero encodes a full 256-byte burst.
  function automatic logic [CNT_W-1:0] burst_target(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order buffer catching FIFO read data; the head entry is always slot0.
module rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head_data
);

  logic [1:0]        occ_q, occ_d;
  logic [DATA_W-1:0] slot0_q, slot0_d;
  logic [DATA_W-1:0] slot1_q, slot1_d;
  logic              push_ok, pop_ok;

  assign pop_ok  = pop && (occ_q != 2'd0);
  assign push_ok = push && ((occ_q != 2'd2) || pop_ok);

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latch).
    occ_d   = occ_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (occ_q == 2'd0) slot0_d = push_data;
        else               slot1_d = push_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd2) begin
          slot0_d = slot1_q;
          slot1_d = push_data;
        end else begin
          slot0_d = push_data;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      occ_q   <= 2'd0;
      // NOTE: data slots are reset as well, so head_data (and m_data) read 0 after reset.
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      occ_q   <= occ_d;
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

  assign occ       = occ_q;
  assign head_data = slot0_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Drains a burst of bytes from a FIFO read port onto a valid/ready stream with m_last and done.
module fifo_rd_drain
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              start,
  input  logic [7:0]        burst_len,
  input  logic              fifo_empty,
  output logic              fifo_r_en,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] deliv_q, deliv_d;
  logic             inflight_q;
  logic [1:0]       occ;
  logic             pop;
  logic [2:0]       fill;

  assign pop     = m_valid && m_ready;
  assign m_valid = (occ != 2'd0);
  assign m_last  = m_valid && (deliv_q == target_q - 9'd1);
  // Entries held or landing next cycle, minus the one leaving now; reads stop when the buffer would overflow.
  assign fill    = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    issued_d  = issued_q;
    deliv_d   = deliv_q;
    fifo_r_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_DRAIN;
          target_d = burst_target(burst_len);
          issued_d = '0;
          deliv_d  = '0;
        end
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        fifo_r_en = !fifo_empty && (issued_q < target_q) && (fill < 3'd2);
        if (fifo_r_en) issued_d = issued_q + 9'd1;
        if (pop) begin
          deliv_d = deliv_q + 9'd1;
          if (m_last) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q    <= ST_IDLE;
      target_q   <= '0;
      issued_q   <= '0;
      deliv_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      issued_q   <= issued_d;
      deliv_q    <= deliv_d;
      inflight_q <= fifo_r_en;
    end
  end

  rd_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .push      (inflight_q),
    .push_data (fifo_rdata),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

endmodule
